// File: rtl/l1dcache_core_if.sv
// Core-side port of the L1 data cache. The load/store client drives the
// access (en/enW/addr/mask/reqData) and the kill strobe; the cache answers
// with hit/respData in the cycle after each access.
interface l1dcache_core_if;
    logic        en;
    logic        enW;
    logic [29:0] addr;
    logic [3:0]  mask;
    logic [31:0] reqData;
    logic        kill;
    logic        hit;
    logic [31:0] respData;

    // Client is the master side (load/store unit), Cache the slave side.
    modport Client (
        output en, enW, addr, mask, reqData, kill,
        input  hit, respData
    );

    modport Cache (
        input  en, enW, addr, mask, reqData, kill,
        output hit, respData
    );
endinterface

// File: rtl/l1dcache_lsu.sv
// Load/store client for the L1 data cache: turns sized byte-address
// requests into word-address/byte-mask accesses, retries misses with a
// fixed backoff, and returns aligned, extended load data as a one-cycle
// completion pulse.
//
// Handshake: a request transfers in the cycle where req_valid && req_ready;
// req_ready is high only in IDLE with no flush. resp_valid is a single-cycle
// pulse with no back-pressure. flush squashes whatever is in flight.
module l1dcache_lsu #(
    parameter int TAG_W     = 4,
    parameter int MAX_RETRY = 15,
    parameter int BACKOFF   = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             req_valid,
    output logic             req_ready,
    input  logic             req_we,
    input  logic [31:0]      req_addr,
    input  logic [1:0]       req_size,
    input  logic             req_unsigned,
    input  logic [31:0]      req_data,
    input  logic [TAG_W-1:0] req_tag,
    input  logic             flush,
    output logic             resp_valid,
    output logic [TAG_W-1:0] resp_tag,
    output logic [31:0]      resp_data,
    output logic [1:0]       resp_err,
    output logic [1:0]       dbg_state,
    l1dcache_core_if.Client  cache
);

    localparam int RC_W = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
    localparam int BO_W = (BACKOFF > 0) ? $clog2(BACKOFF + 1) : 1;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ISSUE   = 2'd1,
        S_CHECK   = 2'd2,
        S_BACKOFF = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Hold registers for the request being serviced.
    logic             we_q, we_d;
    logic [29:0]      addr_q, addr_d;
    logic [1:0]       off_q, off_d;
    logic [1:0]       size_q, size_d;
    logic             uns_q, uns_d;
    logic [3:0]       mask_q, mask_d;
    logic [31:0]      wdata_q, wdata_d;
    logic [TAG_W-1:0] tag_q, tag_d;
    logic [RC_W-1:0]  retry_q, retry_d;
    logic [BO_W-1:0]  bo_q, bo_d;

    logic             resp_valid_q, resp_valid_d;
    logic [TAG_W-1:0] resp_tag_q, resp_tag_d;
    logic [31:0]      resp_data_q, resp_data_d;
    logic [1:0]       resp_err_q, resp_err_d;

    logic [1:0]  in_off;
    logic [3:0]  in_mask;
    logic        in_misalign;
    logic [31:0] in_wdata;
    logic        accept_ok;
    logic        accept_bad;
    logic [31:0] ld_shift;
    logic [31:0] ld_ext;

    assign in_off     = req_addr[1:0];
    assign in_wdata   = req_data << {in_off, 3'b000};
    assign accept_ok  = req_valid && req_ready && !in_misalign;
    assign accept_bad = req_valid && req_ready && in_misalign;
    assign dbg_state  = state_q;

    // Decode the incoming request into a byte mask and an alignment fault.
    always_comb begin
        in_mask     = 4'b0000;
        in_misalign = 1'b0;
        case (req_size)
            2'd0: in_mask = 4'b0001 << in_off;
            2'd1: begin
                in_mask     = 4'b0011 << in_off;
                in_misalign = in_off[0];
            end
            2'd2: begin
                in_mask     = 4'hF;
                in_misalign = (in_off != 2'd0);
            end
            default: in_misalign = 1'b1;
        endcase
    end

    // Align the returned word to the access and extend it to 32 bits.
    always_comb begin
        ld_shift = cache.respData >> {off_q, 3'b000};
        case (size_q)
            2'd0:    ld_ext = {{24{!uns_q && ld_shift[7]}}, ld_shift[7:0]};
            2'd1:    ld_ext = {{16{!uns_q && ld_shift[15]}}, ld_shift[15:0]};
            default: ld_ext = ld_shift;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_IDLE;
        else     state_q <= state_d;
    end

    // Next-state logic; flush always returns to IDLE.
    always_comb begin
        state_d = state_q;
        if (flush) begin
            state_d = S_IDLE;
        end else begin
            case (state_q)
                S_IDLE:  if (accept_ok) state_d = S_CHECK;
                S_ISSUE: state_d = S_CHECK;
                S_CHECK: begin
                    if (cache.hit || retry_q == RC_W'(MAX_RETRY)) state_d = S_IDLE;
                    else if (BACKOFF > 0)                         state_d = S_BACKOFF;
                    else                                          state_d = S_ISSUE;
                end
                S_BACKOFF: if (bo_q == BO_W'(1)) state_d = S_ISSUE;
                default:   state_d = S_IDLE;
            endcase
        end
    end

    // Cache-side outputs and req_ready; everything idle while reset is held.
    always_comb begin
        req_ready     = !rst && (state_q == S_IDLE) && !flush;
        cache.en      = 1'b0;
        cache.enW     = we_q;
        cache.addr    = addr_q;
        cache.mask    = mask_q;
        cache.reqData = wdata_q;
        cache.kill    = 1'b0;
        if (!rst) begin
            case (state_q)
                S_IDLE: begin
                    cache.en      = accept_ok;
                    cache.enW     = req_we;
                    cache.addr    = req_addr[31:2];
                    cache.mask    = in_mask;
                    cache.reqData = in_wdata;
                end
                S_ISSUE: cache.en   = !flush;
                S_CHECK: cache.kill = flush;
                default: ;
            endcase
        end
    end

    // Hold registers, retry/backoff counters and the registered response.
    always_comb begin
        we_d         = we_q;
        addr_d       = addr_q;
        off_d        = off_q;
        size_d       = size_q;
        uns_d        = uns_q;
        mask_d       = mask_q;
        wdata_d      = wdata_q;
        tag_d        = tag_q;
        retry_d      = retry_q;
        bo_d         = bo_q;
        resp_valid_d = 1'b0;
        resp_tag_d   = resp_tag_q;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        case (state_q)
            S_IDLE: begin
                if (accept_ok) begin
                    we_d    = req_we;
                    addr_d  = req_addr[31:2];
                    off_d   = in_off;
                    size_d  = req_size;
                    uns_d   = req_unsigned;
                    mask_d  = in_mask;
                    wdata_d = in_wdata;
                    tag_d   = req_tag;
                    retry_d = '0;
                end else if (accept_bad) begin
                    resp_valid_d = 1'b1;
                    resp_tag_d   = req_tag;
                    resp_data_d  = 32'd0;
                    resp_err_d   = 2'd1;
                end
            end
            S_CHECK: begin
                if (!flush) begin
                    if (cache.hit) begin
                        resp_valid_d = 1'b1;
                        resp_tag_d   = tag_q;
                        resp_data_d  = we_q ? 32'd0 : ld_ext;
                        resp_err_d   = 2'd0;
                    end else if (retry_q == RC_W'(MAX_RETRY)) begin
                        resp_valid_d = 1'b1;
                        resp_tag_d   = tag_q;
                        resp_data_d  = 32'd0;
                        resp_err_d   = 2'd2;
                    end else begin
                        retry_d = retry_q + RC_W'(1);
                        bo_d    = BO_W'(BACKOFF);
                    end
                end
            end
            S_BACKOFF: if (!flush) bo_d = bo_q - BO_W'(1);
            default: ;
        endcase
    end

    // Datapath flops.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            we_q         <= 1'b0;
            addr_q       <= '0;
            off_q        <= '0;
            size_q       <= '0;
            uns_q        <= 1'b0;
            mask_q       <= '0;
            wdata_q      <= '0;
            tag_q        <= '0;
            retry_q      <= '0;
            bo_q         <= '0;
            resp_valid_q <= 1'b0;
            resp_tag_q   <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= '0;
        end else begin
            we_q         <= we_d;
            addr_q       <= addr_d;
            off_q        <= off_d;
            size_q       <= size_d;
            uns_q        <= uns_d;
            mask_q       <= mask_d;
            wdata_q      <= wdata_d;
            tag_q        <= tag_d;
            retry_q      <= retry_d;
            bo_q         <= bo_d;
            resp_valid_q <= resp_valid_d;
            resp_tag_q   <= resp_tag_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_tag   = resp_tag_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_l1dcache_lsu.sv
// Bench for l1dcache_lsu: a simple cache responder with a scripted miss
// count, a byte-level reference memory, and directed plus random requests
// whose latency, access schedule and results are predicted from the
// load/store rules.
module tb_l1dcache_lsu;
    localparam int TAG_W = 4;
    localparam int MR    = 15;
    localparam int BO    = 2;
    localparam int PER   = 2 + BO;

    logic             clk = 1'b0;
    logic             rst = 1'b0;
    logic             req_valid = 1'b0;
    logic             req_ready;
    logic             req_we = 1'b0;
    logic [31:0]      req_addr = '0;
    logic [1:0]       req_size = '0;
    logic             req_unsigned = 1'b0;
    logic [31:0]      req_data = '0;
    logic [TAG_W-1:0] req_tag = '0;
    logic             flush = 1'b0;
    logic             resp_valid;
    logic [TAG_W-1:0] resp_tag;
    logic [31:0]      resp_data;
    logic [1:0]       resp_err;
    logic [1:0]       dbg_state;

    l1dcache_core_if cif ();

    l1dcache_lsu #(.TAG_W(TAG_W), .MAX_RETRY(MR), .BACKOFF(BO)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_size(req_size), .req_unsigned(req_unsigned),
        .req_data(req_data), .req_tag(req_tag), .flush(flush),
        .resp_valid(resp_valid), .resp_tag(resp_tag), .resp_data(resp_data),
        .resp_err(resp_err), .dbg_state(dbg_state),
        .cache(cif.Client)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int passed = 0;
    int fails = 0;
    int cyc = 0;
    int miss_left = 0;
    int resp_seen = 0;
    int kill_seen = 0;
    int acc_q[$];
    logic [31:0] cmem [64];
    logic [7:0]  ref_mem [256];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks = checks + 1;
        assert (obs === exp) passed = passed + 1;
        else begin
            fails = fails + 1;
            $error("FAIL %s: observed %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    // One clock: sample the access before the edge, answer it after the edge.
    task automatic step();
        logic        s_en, s_we;
        logic [29:0] s_a;
        logic [3:0]  s_m;
        logic [31:0] s_d;
        #1;
        s_en = cif.en; s_we = cif.enW; s_a = cif.addr; s_m = cif.mask; s_d = cif.reqData;
        if (cif.kill) kill_seen++;
        @(posedge clk);
        #1;
        cyc++;
        if (resp_valid) resp_seen++;
        if (s_en) begin
            acc_q.push_back(cyc - 1);
            if (miss_left > 0) begin
                miss_left--;
                cif.hit = 1'b0;
                cif.respData = $urandom;
            end else begin
                cif.hit = 1'b1;
                cif.respData = cmem[s_a[5:0]];
                if (s_we)
                    for (int b = 0; b < 4; b++)
                        if (s_m[b]) cmem[s_a[5:0]][8*b +: 8] = s_d[8*b +: 8];
            end
        end else begin
            cif.hit = 1'b0;
            cif.respData = $urandom;
        end
    endtask

    function automatic logic [31:0] ref_load(input logic [31:0] a, input int nb, input bit uns);
        logic [31:0] v;
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v | (32'(ref_mem[(a + i) & 255]) << (8 * i));
        if (!uns && nb < 4 && v[8*nb-1]) v = v | ~((32'd1 << (8 * nb)) - 32'd1);
        return v;
    endfunction

    // Issue one request, then check the access schedule and the response.
    task automatic do_req(input bit we, input logic [31:0] a, input logic [1:0] sz, input bit uns,
                          input logic [31:0] d, input logic [TAG_W-1:0] tg, input int misses);
        int off, nb, n_acc, lat, guard, n0;
        bit mis, got;
        logic [1:0] err;
        logic [3:0] emask;
        logic [31:0] edata;
        off = int'(a[1:0]);
        nb  = 1 << sz;
        mis = (sz == 2'd3) || (off % nb != 0);
        emask = 4'(((1 << nb) - 1) << off);
        n_acc = mis ? 0 : ((misses > MR) ? MR + 1 : misses + 1);
        lat   = mis ? 1 : 2 + (n_acc - 1) * PER;
        err   = mis ? 2'd1 : ((misses > MR) ? 2'd2 : 2'd0);
        edata = (mis || we || err != 2'd0) ? 32'd0 : ref_load(a, nb, uns);

        acc_q.delete();
        kill_seen = 0;
        miss_left = misses;
        req_valid = 1'b1; req_we = we; req_addr = a; req_size = sz;
        req_unsigned = uns; req_data = d; req_tag = tg;
        #1;
        guard = 0;
        while (!req_ready && guard < 50) begin
            step();
            guard++;
            #1;
        end
        chk("req_ready", {31'd0, req_ready}, 32'd1);
        chk("acc_en", {31'd0, cif.en}, {31'd0, !mis});
        if (!mis) begin
            chk("acc_addr", {2'b00, cif.addr}, a >> 2);
            chk("acc_mask", {28'd0, cif.mask}, {28'd0, emask});
            chk("acc_we", {31'd0, cif.enW}, {31'd0, we});
            if (we) chk("acc_wdata", cif.reqData, d << (8 * off));
        end
        n0 = cyc;
        step();
        req_valid = 1'b0;
        got = 1'b0;
        for (int t = 0; t < lat + 20 && !got; t++) begin
            if (resp_valid) got = 1'b1;
            else step();
        end
        chk("resp_seen", {31'd0, got}, 32'd1);
        chk("resp_cycle", cyc - n0, lat);
        chk("resp_tag", {28'd0, resp_tag}, {28'd0, tg});
        chk("resp_err", {30'd0, resp_err}, {30'd0, err});
        chk("resp_data", resp_data, edata);
        chk("idle_at_resp", {30'd0, dbg_state}, 32'd0);
        chk("acc_count", acc_q.size(), n_acc);
        for (int k = 0; k < acc_q.size() && k < n_acc; k++)
            chk("acc_cycle", acc_q[k] - n0, k * PER);
        chk("no_kill", kill_seen, 32'd0);
        if (we && err == 2'd0)
            for (int i = 0; i < nb; i++) ref_mem[(a + i) & 255] = d[8*i +: 8];
        miss_left = 0;
    endtask

    // Accept a long-missing load and walk it into CHECK or BACKOFF.
    task automatic start_missing_load(input int steps_after);
        acc_q.delete();
        resp_seen = 0;
        miss_left = 1000;
        req_valid = 1'b1; req_we = 1'b0; req_addr = 32'h0000_1010;
        req_size = 2'd2; req_unsigned = 1'b0; req_tag = 4'h9;
        #1;
        chk("flush_tc_ready", {31'd0, req_ready}, 32'd1);
        step();
        req_valid = 1'b0;
        repeat (steps_after) step();
    endtask

    task automatic expect_quiet(input string tag);
        repeat (12) step();
        chk({tag, "_no_resp"}, resp_seen, 32'd0);
        chk({tag, "_one_access"}, acc_q.size(), 32'd1);
        miss_left = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v;
        cif.hit = 1'b0;
        cif.respData = '0;
        for (int w = 0; w < 64; w++) begin
            v = $urandom;
            cmem[w] = v;
            for (int b = 0; b < 4; b++) ref_mem[4*w + b] = v[8*b +: 8];
        end

        // Reset values, with a request offered while reset is held.
        #1 rst = 1'b1;
        req_valid = 1'b1;
        #20;
        chk("rst_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_en", {31'd0, cif.en}, 32'd0);
        chk("rst_kill", {31'd0, cif.kill}, 32'd0);
        chk("rst_resp_valid", {31'd0, resp_valid}, 32'd0);
        chk("rst_resp_tag", {28'd0, resp_tag}, 32'd0);
        chk("rst_resp_data", resp_data, 32'd0);
        chk("rst_resp_err", {30'd0, resp_err}, 32'd0);
        chk("rst_state", {30'd0, dbg_state}, 32'd0);
        req_valid = 1'b0;
        @(posedge clk);
        #1;
        rst = 1'b0;
        cyc = 0;

        // Signed byte load from the top byte of a word.
        cmem[0] = 32'h80FF_0000;
        ref_mem[0] = 8'h00; ref_mem[1] = 8'h00; ref_mem[2] = 8'hFF; ref_mem[3] = 8'h80;
        do_req(1'b0, 32'h0000_1003, 2'd0, 1'b0, 32'd0, 4'h3, 0);
        chk("tp_signed_byte", resp_data, 32'hFFFF_FF80);

        // Half store into the upper half, read back unsigned and signed.
        do_req(1'b1, 32'h0000_2002, 2'd1, 1'b0, 32'h0000_BEEF, 4'hA, 0);
        do_req(1'b0, 32'h0000_2002, 2'd1, 1'b1, 32'd0, 4'h1, 0);
        chk("tp_half_readback", resp_data, 32'h0000_BEEF);
        do_req(1'b0, 32'h0000_2002, 2'd1, 1'b0, 32'd0, 4'h2, 0);
        chk("tp_half_signed", resp_data, 32'hFFFF_BEEF);

        // Word load that misses twice, then a store that never hits.
        do_req(1'b0, 32'h0000_1004, 2'd2, 1'b0, 32'd0, 4'h4, 2);
        do_req(1'b1, 32'h0000_1008, 2'd2, 1'b0, 32'h1234_5678, 4'h5, 1000);

        // Misaligned requests make no access.
        do_req(1'b0, 32'h0000_1001, 2'd1, 1'b0, 32'd0, 4'h6, 0);
        do_req(1'b0, 32'h0000_1002, 2'd2, 1'b0, 32'd0, 4'h7, 0);
        do_req(1'b1, 32'h0000_1000, 2'd3, 1'b0, 32'hFFFF_FFFF, 4'h8, 0);

        // Flush while in CHECK, with a new request offered the same cycle.
        start_missing_load(0);
        flush = 1'b1;
        req_valid = 1'b1;
        #1;
        chk("flush_check_kill", {31'd0, cif.kill}, 32'd1);
        chk("flush_check_ready", {31'd0, req_ready}, 32'd0);
        chk("flush_check_en", {31'd0, cif.en}, 32'd0);
        step();
        flush = 1'b0;
        req_valid = 1'b0;
        chk("flush_check_idle", {30'd0, dbg_state}, 32'd0);
        expect_quiet("flush_check");

        // Flush while backing off.
        start_missing_load(1);
        flush = 1'b1;
        #1;
        chk("flush_bo_kill", {31'd0, cif.kill}, 32'd0);
        step();
        flush = 1'b0;
        chk("flush_bo_idle", {30'd0, dbg_state}, 32'd0);
        expect_quiet("flush_bo");

        // Asynchronous reset pulse while backing off.
        start_missing_load(1);
        #1 rst = 1'b1;
        #1;
        chk("arst_state", {30'd0, dbg_state}, 32'd0);
        chk("arst_ready", {31'd0, req_ready}, 32'd0);
        chk("arst_resp_tag", {28'd0, resp_tag}, 32'd0);
        chk("arst_resp_data", resp_data, 32'd0);
        step();
        rst = 1'b0;
        expect_quiet("arst");
        do_req(1'b0, 32'h0000_1020, 2'd2, 1'b0, 32'd0, 4'hC, 0);

        // Random mix of loads and stores with scripted miss counts.
        for (int n = 0; n < 40; n++) begin
            logic [31:0] a;
            logic [1:0]  sz;
            int ms;
            sz = ($urandom_range(0, 7) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
            a = 32'h0000_1000 | 32'($urandom_range(0, 255));
            if (sz != 2'd3 && $urandom_range(0, 3) != 0) a = a & ~(32'(1 << sz) - 32'd1);
            case ($urandom_range(0, 15))
                10, 11: ms = 1;
                12, 13: ms = 2;
                14:     ms = 5;
                15:     ms = 1000;
                default: ms = 0;
            endcase
            do_req(1'($urandom_range(0, 1)), a, sz, 1'($urandom_range(0, 1)),
                   $urandom, 4'($urandom_range(0, 15)), ms);
        end

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
